// File: rtl/iic_pkg.sv
// Shared IIC sequencer definitions: state encoding, engine phase bit
// positions and the default per-phase timeout.
package iic_pkg;

  localparam logic [2:0] IIC_ST_IDLE  = 3'd0;
  localparam logic [2:0] IIC_ST_START = 3'd1;
  localparam logic [2:0] IIC_ST_CHIP  = 3'd2;
  localparam logic [2:0] IIC_ST_REG   = 3'd3;
  localparam logic [2:0] IIC_ST_WAITD = 3'd4;
  localparam logic [2:0] IIC_ST_DATA  = 3'd5;
  localparam logic [2:0] IIC_ST_STOP  = 3'd6;
  localparam logic [2:0] IIC_ST_GAP   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = IIC_ST_IDLE,
    ST_START = IIC_ST_START,
    ST_CHIP  = IIC_ST_CHIP,
    ST_REG   = IIC_ST_REG,
    ST_WAITD = IIC_ST_WAITD,
    ST_DATA  = IIC_ST_DATA,
    ST_STOP  = IIC_ST_STOP,
    ST_GAP   = IIC_ST_GAP
  } iic_state_e;

  // Bit positions of the engine phase vectors {stop, data, reg, chip, start}.
  localparam int PH_START = 0;
  localparam int PH_CHIP  = 1;
  localparam int PH_REG   = 2;
  localparam int PH_DATA  = 3;
  localparam int PH_STOP  = 4;

  localparam int IIC_DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/iic_wr_seq.sv
// IIC write sequencer: drives the bit-level engine through
// START -> CHIP -> REG -> (WAITD -> DATA) x N -> STOP for one request.
// Optional per-phase abort timer: define IIC_SEQ_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | ready for a request
//  START | engine issuing START condition
//  CHIP  | engine shifting chip byte
//  REG   | engine shifting register byte
//  WAITD | waiting for next data byte, engine idle
//  DATA  | engine shifting a data byte
//  STOP  | engine issuing STOP condition
//  GAP   | one idle cycle between phases, selects the next phase
module iic_wr_seq
  import iic_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = IIC_DEFAULT_TIMEOUT,
  parameter int TO_W    = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_chip,
  input  logic [7:0]       req_reg,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [7:0]       wd_data,
  output logic             trans_start,
  output logic             trans_chip,
  output logic             trans_reg,
  output logic             trans_data,
  output logic             trans_stop,
  input  logic             finish_start,
  input  logic             finish_chip,
  input  logic             finish_reg,
  input  logic             finish_data,
  input  logic             finish_stop,
  output logic [7:0]       data_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] CNT_ONE = 1;

  iic_state_e       state_q, state_d, nxt_q, nxt_d;
  logic [7:0]       chip_q, chip_d, reg_q, reg_d, byte_q, byte_d;
  logic [7:0]       data_in_q, data_in_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [4:0]       fin_cur, fin_rise, fin_prev_q, fin_prev_d;
  logic [4:0]       trans_q, trans_d;
  logic             req_ready_q, req_ready_d, wd_ready_q, wd_ready_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             phase_done;

`ifdef IIC_SEQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_ONE  = 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            abort_q, abort_d;
  logic            to_run, to_hit;
`else
  logic [TO_W-1:0] unused_to;
  assign unused_to = TO_W'(TIMEOUT);
`endif

  assign fin_cur  = {finish_stop, finish_data, finish_reg, finish_chip, finish_start};
  assign fin_rise = fin_cur & ~fin_prev_q;

  // Only a rising edge of the active phase's own finish completes it.
  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      ST_START: phase_done = fin_rise[PH_START];
      ST_CHIP:  phase_done = fin_rise[PH_CHIP];
      ST_REG:   phase_done = fin_rise[PH_REG];
      ST_DATA:  phase_done = fin_rise[PH_DATA];
      ST_STOP:  phase_done = fin_rise[PH_STOP];
      default:  phase_done = 1'b0;
    endcase
  end

  // Next state, captured request fields, and outputs decoded from the next state.
  always_comb begin
    state_d    = state_q;
    nxt_d      = nxt_q;
    chip_d     = chip_q;
    reg_d      = reg_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    fin_prev_d = fin_cur;
    wd_ready_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef IIC_SEQ_TIMEOUT_EN
    abort_d    = abort_q;
    to_run     = 1'b0;
    to_hit     = 1'b0;
    to_cnt_d   = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          chip_d  = req_chip;
          reg_d   = req_reg;
          len_d   = req_len;
          cnt_d   = '0;
          state_d = ST_START;
`ifdef IIC_SEQ_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      ST_START: if (phase_done) begin nxt_d = ST_CHIP;  state_d = ST_GAP; end
      ST_CHIP:  if (phase_done) begin nxt_d = ST_REG;   state_d = ST_GAP; end
      ST_REG:   if (phase_done) begin nxt_d = ST_WAITD; state_d = ST_GAP; end
      ST_WAITD: begin
        if (wd_valid) begin
          byte_d     = wd_data;
          wd_ready_d = 1'b1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (phase_done) begin
          state_d = ST_GAP;
          if (cnt_q == len_q) begin
            nxt_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            nxt_d = ST_WAITD;
          end
        end
      end
      ST_STOP: begin
        if (phase_done) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef IIC_SEQ_TIMEOUT_EN
          err_d   = abort_q;
`endif
        end
      end
      ST_GAP:  state_d = nxt_q;
      default: state_d = ST_IDLE;
    endcase

`ifdef IIC_SEQ_TIMEOUT_EN
    // A completion in the same cycle as the last allowed count wins.
    to_run = (state_q inside {ST_START, ST_CHIP, ST_REG, ST_DATA, ST_STOP});
    to_hit = to_run && !phase_done && (to_cnt_q == TO_LAST);
    if (to_hit) begin
      if (state_q == ST_STOP) begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        abort_d = 1'b1;
        nxt_d   = ST_STOP;
        state_d = ST_GAP;
      end
    end
    if (state_d != state_q)
      to_cnt_d = '0;
    else if (to_run)
      to_cnt_d = to_cnt_q + TO_ONE;
`endif

    trans_d   = '0;
    data_in_d = 8'h00;
    case (state_d)
      ST_START: trans_d[PH_START] = 1'b1;
      ST_CHIP:  begin trans_d[PH_CHIP] = 1'b1; data_in_d = chip_d; end
      ST_REG:   begin trans_d[PH_REG]  = 1'b1; data_in_d = reg_d;  end
      ST_DATA:  begin trans_d[PH_DATA] = 1'b1; data_in_d = byte_d; end
      ST_STOP:  trans_d[PH_STOP] = 1'b1;
      default:  trans_d = '0;
    endcase
    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      nxt_q       <= ST_IDLE;
      chip_q      <= 8'h00;
      reg_q       <= 8'h00;
      len_q       <= '0;
      cnt_q       <= '0;
      byte_q      <= 8'h00;
      fin_prev_q  <= '0;
      trans_q     <= '0;
      data_in_q   <= 8'h00;
      req_ready_q <= 1'b1;
      wd_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IIC_SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      nxt_q       <= nxt_d;
      chip_q      <= chip_d;
      reg_q       <= reg_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      fin_prev_q  <= fin_prev_d;
      trans_q     <= trans_d;
      data_in_q   <= data_in_d;
      req_ready_q <= req_ready_d;
      wd_ready_q  <= wd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IIC_SEQ_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      abort_q     <= abort_d;
`endif
    end
  end

  // wd_ready acknowledges the byte in the cycle after it was latched.
  assign req_ready   = req_ready_q;
  assign wd_ready    = wd_ready_q;
  assign trans_start = trans_q[PH_START];
  assign trans_chip  = trans_q[PH_CHIP];
  assign trans_reg   = trans_q[PH_REG];
  assign trans_data  = trans_q[PH_DATA];
  assign trans_stop  = trans_q[PH_STOP];
  assign data_in     = data_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
